// File: rtl/usr_tx_sched.sv
// Round-robin scheduler for two word requesters feeding a universal shift register,
// sequencing clear, parallel load and MSB-first shifting into a framed serial stream.
module usr_tx_sched #(
    parameter int   WIDTH = 4,
    parameter logic FILL  = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             req0_valid_i,
    input  logic [WIDTH-1:0] req0_data_i,
    output logic             req0_ready_o,
    input  logic             req1_valid_i,
    input  logic [WIDTH-1:0] req1_data_i,
    output logic             req1_ready_o,
    output logic [1:0]       mode_o,
    output logic [WIDTH-1:0] datain_o,
    input  logic [WIDTH-1:0] dataout_i,
    output logic             ser_out_o,
    output logic             ser_valid_o,
    output logic             ser_first_o,
    output logic             ser_last_o,
    output logic             ser_owner_o,
    output logic             busy_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {CLR, IDLE, LOAD, SHIFT} state_t;

    state_t           state_q, state_d, state_eff;
    logic             last_owner_q, last_owner_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             grant;

    // Requester 1 wins when it is alone, or on a tie when requester 0 was served last.
    assign grant       = req1_valid_i && (!req0_valid_i || !last_owner_q);
    // While reset is held the outputs already look like CLR.
    assign state_eff   = rst_n_i ? state_q : CLR;
    assign ser_owner_o = owner_q;
    assign busy_o      = (state_eff != IDLE);

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        hold_d       = hold_q;
        cnt_d        = cnt_q;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        mode_o       = 2'b00;
        datain_o     = '0;
        ser_out_o    = 1'b0;
        ser_valid_o  = 1'b0;
        ser_first_o  = 1'b0;
        ser_last_o   = 1'b0;
        case (state_eff)
            CLR: begin
                mode_o  = 2'b11;
                state_d = IDLE;
            end
            IDLE: begin
                req0_ready_o = req0_valid_i && !grant;
                req1_ready_o = grant;
                if (req0_ready_o || req1_ready_o) begin
                    hold_d       = grant ? req1_data_i : req0_data_i;
                    owner_d      = grant;
                    last_owner_d = grant;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                mode_o   = 2'b11;
                datain_o = hold_q;
                cnt_d    = '0;
                state_d  = SHIFT;
            end
            SHIFT: begin
                mode_o      = 2'b10;
                datain_o    = WIDTH'(FILL);
                ser_valid_o = 1'b1;
                ser_out_o   = dataout_i[WIDTH-1];
                ser_first_o = (cnt_q == '0);
                ser_last_o  = (cnt_q == CW'(WIDTH - 1));
                cnt_d       = cnt_q + CW'(1);
                if (ser_last_o) begin
                    state_d = IDLE;
                end
            end
            default: state_d = CLR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= CLR;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            hold_q       <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            hold_q       <= hold_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_usr_tx_sched.sv
// Scoreboard bench for usr_tx_sched: a timing-level grant model pushes expected serial
// bits, a negedge monitor pops and compares them; a second instance exercises FILL=1.
module tb_usr_tx_sched;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         v0, v1, r0, r1;
    logic [W-1:0] d0, d1;
    logic [1:0]   mode;
    logic [W-1:0] datain, sr;
    logic         sout, sv, sfirst, slast, sowner, busy;

    logic         fv, fr, fr1;
    logic [W-1:0] fd, fdatain, fsr;
    logic [1:0]   fmode;
    logic         fsout, fsv, fsfirst, fslast, fsowner, fbusy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    usr_tx_sched #(.WIDTH(W), .FILL(1'b0)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_valid_i(v0), .req0_data_i(d0), .req0_ready_o(r0),
        .req1_valid_i(v1), .req1_data_i(d1), .req1_ready_o(r1),
        .mode_o(mode), .datain_o(datain), .dataout_i(sr),
        .ser_out_o(sout), .ser_valid_o(sv), .ser_first_o(sfirst), .ser_last_o(slast),
        .ser_owner_o(sowner), .busy_o(busy)
    );

    usr_tx_sched #(.WIDTH(W), .FILL(1'b1)) u_fill (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_valid_i(fv), .req0_data_i(fd), .req0_ready_o(fr),
        .req1_valid_i(1'b0), .req1_data_i('0), .req1_ready_o(fr1),
        .mode_o(fmode), .datain_o(fdatain), .dataout_i(fsr),
        .ser_out_o(fsout), .ser_valid_o(fsv), .ser_first_o(fsfirst), .ser_last_o(fslast),
        .ser_owner_o(fsowner), .busy_o(fbusy)
    );

    // Behavioural universal shift registers, preloaded with all ones.
    initial begin sr = 4'hF; fsr = 4'hF; end
    always @(posedge clk) begin
        case (mode)
            2'b11:   sr <= datain;
            2'b10:   sr <= {sr[W-2:0], datain[0]};
            2'b01:   sr <= {1'b0, sr[W-1:1]};
            default: ;
        endcase
        case (fmode)
            2'b11:   fsr <= fdatain;
            2'b10:   fsr <= {fsr[W-2:0], fdatain[0]};
            2'b01:   fsr <= {1'b0, fsr[W-1:1]};
            default: ;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a word accepted in cycle T emits bit i at cycle T+2+i; the
    // scheduler is free again at T+6; reset makes it free two cycles after the last low cycle.
    typedef struct {
        int t;
        bit b;
        bit f;
        bit l;
        bit o;
    } exp_t;

    exp_t         exq[$];
    int           idle_at = 0;
    bit           lo      = 1'b1;
    bit           mon_en  = 1'b1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                exq.delete();
                idle_at = cyc + 2;
                lo      = 1'b1;
                chk("reset_outs", {r0, r1, busy, mode, datain, sv, sfirst, slast, sout},
                    {1'b0, 1'b0, 1'b1, 2'b11, 4'h0, 4'h0});
            end else begin
                bit e0, e1, g;
                logic [W-1:0] w;
                e0 = 1'b0; e1 = 1'b0; g = 1'b0;
                if (cyc >= idle_at && (v0 || v1)) begin
                    g  = (v0 && v1) ? !lo : v1;
                    e0 = !g;
                    e1 = g;
                end
                chk("ready", {r0, r1}, {e0, e1});
                chk("busy", busy, cyc < idle_at);
                if (e0 || e1) begin
                    lo = g;
                    w  = g ? d1 : d0;
                    for (int i = 0; i < W; i++)
                        exq.push_back('{cyc + 2 + i, w[W-1-i], i == 0, i == W - 1, g});
                    idle_at = cyc + W + 2;
                end
            end
            if (sv) begin
                if (exq.size() == 0) begin
                    chk("unexpected_bit", 1, 0);
                end else begin
                    exp_t e;
                    e = exq.pop_front();
                    chk("bit", {cyc, sout, sfirst, slast, sowner}, {e.t, e.b, e.f, e.l, e.o});
                end
            end else begin
                chk("ser_quiet", {sout, sfirst, slast}, 3'b000);
                if (exq.size() > 0 && exq[0].t <= cyc) begin
                    chk("missing_bit", 0, 1);
                    void'(exq.pop_front());
                end
            end
        end
    end

    task automatic wait_rdy(input bit which);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = which ? r1 : r0;
        end
        if (!got) chk("hs_timeout", 0, 1);
        @(posedge clk); #1;
        if (which) v1 = 1'b0; else v0 = 1'b0;
    endtask

    initial begin
        logic [W-1:0] fbits;
        int           nb;
        bit           done;
        rst_n = 1'b0; v0 = 0; v1 = 0; d0 = '0; d1 = '0; fv = 0; fd = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("clr_mode", {mode, datain, busy}, {2'b11, 4'h0, 1'b1});
        @(negedge clk);
        chk("idle_after_clr", {mode, busy, sr}, {2'b00, 1'b0, 4'h0});

        // Persistent tie: grants alternate starting with requester 0.
        @(posedge clk); #1;
        v0 = 1; d0 = 4'h5; v1 = 1; d1 = 4'hA;
        repeat (18) @(posedge clk);
        #1 v0 = 0; v1 = 0;
        repeat (8) @(posedge clk);

        #1 v0 = 1; d0 = 4'hB;
        wait_rdy(1'b0);
        repeat (8) @(posedge clk);

        // Reset in the third shift cycle drops the word.
        #1 v0 = 1; d0 = 4'hC;
        wait_rdy(1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        v1 = 1; d1 = 4'h3;
        wait_rdy(1'b1);
        repeat (8) @(posedge clk);

        // Requester 1 arrives while requester 0's word is shifting.
        #1 v0 = 1; d0 = 4'h6;
        wait_rdy(1'b0);
        repeat (2) @(posedge clk);
        #1 v1 = 1; d1 = 4'h9;
        wait_rdy(1'b1);

        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 2) != 0);
            d0 = W'($urandom);
            d1 = W'($urandom);
        end
        #1 v0 = 0; v1 = 0;
        repeat (10) @(posedge clk);
        chk("drain", exq.size(), 0);

        // FILL=1 instance: ones are shifted in behind the word.
        #1 fv = 1; fd = 4'h8;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = fr;
        end
        chk("fill_hs", done, 1);
        @(posedge clk); #1 fv = 0;
        fbits = '0; nb = 0; done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            @(negedge clk);
            if (fsv) begin
                fbits = {fbits[W-2:0], fsout};
                nb++;
                done = fslast;
            end
        end
        chk("fill_bits", {nb, fbits}, {32'd4, 4'h8});
        @(posedge clk); #1;
        chk("fill_dataout", fsr, 4'hF);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
